dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single-port data RAM (14-bit word address, 32-bit data, 1-cycle synchronous read) between two requesters: the CPU load/store path and the UART programmer write stream.
- Sits between those requesters and the RAM port.
- Uses a req/ack handshake on each side.
- Grants round-robin, so neither requester can starve the other.
- Counts UART words committed, for status LEDs.

Parameters:
ADDR_W, 14, RAM word-address width
DATA_W, 32, RAM data width
CNT_W, 15, width of the committed-UART-word counter (ADDR_W+1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
cpu_req  in  1  CPU request; held with payload stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DATA_W  read data, valid with cpu_ack, held until next CPU read completes
upg_req  in  1  UART programmer write request; held until upg_ack
upg_addr  in  ADDR_W  UART word address
upg_wdata  in  DATA_W  UART write data
upg_ack  out  1  one-cycle completion pulse to UART side
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read-enable cycle
busy  out  1  1 whenever state != IDLE
owner  out  1  0 = CPU, 1 = UART; owner of the current or most recent access
upg_words  out  CNT_W  count of committed UART writes, saturating

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE, cpu_ack=0, upg_ack=0, cpu_rdata=0, owner=0, upg_words=0, last-served flag=UART (CPU wins the first tie).
- RAM is not reset. A write whose ACCESS cycle coincides with the reset edge still commits in RAM, but no ack is issued. All other in-flight work is dropped.
- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - Samples cpu_req and upg_req.
  - If exactly one is high, that requester wins.
  - If both are high, the one not last served wins.
  - On a win: latch owner, we (upg forces we=1), address and wdata into registers, then go to ACCESS. If neither is high, stay in IDLE.
- ACCESS: ram_en=1, ram_we=latched we, ram_addr and ram_wdata from latched registers. Next state is WAIT for a read, ACK for a write.
- WAIT (reads only): ram_en=0. Capture ram_rdata into cpu_rdata at the end of this cycle. Next state is ACK.
- ACK:
  - The owner's ack is 1 for exactly this cycle; the other ack is 0.
  - The last-served flag updates to owner.
  - If owner=UART, upg_words increments, holding at 2^CNT_W-1.
  - Next state is always IDLE.
- Outside ACCESS: ram_en=0, ram_we=0. ram_addr and ram_wdata hold their latched values.
- Latency, counted from the IDLE cycle that samples the request: write ack at +2 cycles, read ack at +3 cycles.
- Throughput: one write per 3 cycles, one read per 4 cycles.
- Requester rule: the requester deasserts req (or presents its next request) at the edge ending its ack cycle. The arbiter never samples a request during ACK, so a completed request is never granted twice.
- Payload and req changes while not yet granted are legal; the arbiter uses the values present in the IDLE sampling cycle.
- Dropping req before ack is a protocol violation and does not abort the access.
- Read data: cpu_rdata changes only at the end of a CPU-read WAIT cycle. CPU writes and all UART accesses leave it unchanged.
- Fairness: under continuous requests from both sides, grants strictly alternate CPU, UART, CPU, and so on. Worst-case wait before a grant is one foreign access, at most 4 cycles.

Decomposition:
- Shared package:
  - FSM state encoding: localparams S_IDLE=2'd0, S_ACCESS=2'd1, S_WAIT=2'd2, S_ACK=2'd3.
  - Owner constants OWN_CPU=1'b0, OWN_UPG=1'b1.
- Natural sub-module: rr_pick2, a two-requester round-robin selector with inputs req[1:0] and last and outputs grant and valid. It is combinational and is instantiated once.
- FSM, latches, ack logic and counter stay in dmem_arbiter.

Test Plan:
- CPU write, then CPU read: cpu_req=1, we=1, addr=0x0010, wdata=0xDEADBEEF gives cpu_ack 2 cycles later with ram_we high for one cycle. A following read of 0x0010 gives cpu_ack at +3 with cpu_rdata=0xDEADBEEF.
- UART stream: 5 back-to-back UART writes, addresses 0..4 with data 0x1000+i. Each upg_ack arrives 2 cycles after sampling, 3-cycle spacing, and upg_words=5 at the end.
- Contention: cpu_req (read) and upg_req held continuously from reset. Grant order is CPU, UART, CPU, UART, and upg_words increments only on UART acks.
- Reset mid-operation: rst=0 at the edge ending the WAIT of a CPU read. Next cycle state=IDLE, busy=0, cpu_ack never pulses, cpu_rdata=0, upg_words=0.
- Reset during ACCESS of a UART write to 0x0020 with data 0xA5A5A5A5: RAM holds 0xA5A5A5A5, upg_ack=0, upg_words=0.
- Saturation with CNT_W=3: 9 UART writes give upg_words 1..7, then it holds at 7.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states and owner identifiers.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_UPG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and RAM-port signals of the data-RAM arbiter; slave is the arbiter view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              upg_req;
    logic [ADDR_W-1:0] upg_addr;
    logic [DATA_W-1:0] upg_wdata;
    logic              upg_ack;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  upg_req, upg_addr, upg_wdata,
        output upg_ack,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output upg_req, upg_addr, upg_wdata,
        input  upg_ack,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);
    assign valid = |req;
    assign grant = (req == 2'b11) ? ~last : req[1];
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU and the UART programmer.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    dmem_arbiter_if.slave    bus,
    output logic             busy,
    output logic             owner,
    output logic [CNT_W-1:0] upg_words
);

    arb_state_t        state, state_nxt;
    logic              last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  words_q;
    logic              pick;
    logic              pick_vld;
    logic              grant_now;

    rr_pick2 u_pick (
        .req   ({bus.upg_req, bus.cpu_req}),
        .last  (last_q),
        .grant (pick),
        .valid (pick_vld)
    );

    assign grant_now = (state == S_IDLE) && pick_vld;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            owner   <= OWN_CPU;
            last_q  <= OWN_UPG;
            rdata_q <= '0;
            words_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant_now)
                owner <= pick;
            if (state == S_WAIT)
                rdata_q <= bus.ram_rdata;
            if (state == S_ACK) begin
                last_q <= owner;
                if (owner == OWN_UPG && words_q != {CNT_W{1'b1}})
                    words_q <= words_q + 1'b1;
            end
        end
    end

    // Payload latches are not reset: they only matter once a grant has loaded them.
    always_ff @(posedge clk) begin
        if (grant_now) begin
            we_q    <= (pick == OWN_UPG) ? 1'b1 : bus.cpu_we;
            addr_q  <= (pick == OWN_UPG) ? bus.upg_addr : bus.cpu_addr;
            wdata_q <= (pick == OWN_UPG) ? bus.upg_wdata : bus.cpu_wdata;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.ram_en  = 1'b0;
        bus.ram_we  = 1'b0;
        bus.cpu_ack = 1'b0;
        bus.upg_ack = 1'b0;
        case (state)
            S_IDLE:   if (pick_vld) state_nxt = S_ACCESS;
            S_ACCESS: begin
                bus.ram_en = 1'b1;
                bus.ram_we = we_q;
                state_nxt  = we_q ? S_ACK : S_WAIT;
            end
            S_WAIT:   state_nxt = S_ACK;
            S_ACK: begin
                bus.cpu_ack = (owner == OWN_CPU);
                bus.upg_ack = (owner == OWN_UPG);
                state_nxt   = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.cpu_rdata = rdata_q;
    assign busy          = (state != S_IDLE);
    assign upg_words     = words_q;

endmodule
